// File: rtl/align_shift_grs.sv
// align_shift_grs: iterative right-shift aligner producing guard/round/sticky.
// A latched shift amount is applied one binary stage per cycle, most
// significant stage first, over a (MANT_W+2)-bit {mant, g, r} working register.
// Bits falling off the bottom of the working register accumulate into sticky.
// Optional feature macro: ALIGN_EARLY_EXIT_EN -- finish as soon as no set
// shift bits remain below the stage just processed; results are unchanged.
module align_shift_grs #(
  parameter int MANT_W  = 24,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  mant_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  mant_out,
  output logic               g,
  output logic               r,
  output logic               s,
  output logic               busy
);

  localparam int W  = MANT_W + 2;
  localparam int KW = (SHIFT_W > 1) ? $clog2(SHIFT_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       work_q, work_d;
  logic               sticky_q, sticky_d;
  logic [SHIFT_W-1:0] amt_q, amt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [MANT_W-1:0]  mant_q, mant_d;
  logic               g_q, g_d, r_q, r_d, s_q, s_d;

  // Per-stage candidates: working register shifted by 2^gi and the OR of the
  // bits that shift discards. Stages at least as wide as the register flush it.
  logic [W-1:0] stage_work [SHIFT_W];
  logic         stage_lost [SHIFT_W];

  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_W; gi++) begin : g_stage
      if (gi >= $clog2(W)) begin : g_flush
        assign stage_work[gi] = '0;
        assign stage_lost[gi] = |work_q;
      end else begin : g_part
        localparam int D = 1 << gi;
        assign stage_work[gi] = work_q >> D;
        assign stage_lost[gi] = |work_q[D-1:0];
      end
    end
  endgenerate

  logic [W-1:0] sel_work;
  logic         sel_lost;
  logic         bit_set;
  logic [W-1:0] shifted_work;
  logic         shifted_sticky;
  logic         last_stage;

  // Pick the stage selected by k and decide whether this is the final stage.
  always_comb begin
    sel_work = work_q;
    sel_lost = 1'b0;
    bit_set  = 1'b0;
    for (int i = 0; i < SHIFT_W; i++) begin
      if (int'(k_q) == i) begin
        sel_work = stage_work[i];
        sel_lost = stage_lost[i];
        bit_set  = amt_q[i];
      end
    end
    shifted_work   = bit_set ? sel_work : work_q;
    shifted_sticky = sticky_q | (bit_set & sel_lost);
`ifdef ALIGN_EARLY_EXIT_EN
    // Finished once no set shift bit remains below the current stage.
    last_stage = 1'b1;
    for (int i = 0; i < SHIFT_W; i++) begin
      if (amt_q[i] && (i < int'(k_q))) last_stage = 1'b0;
    end
`else
    last_stage = (k_q == '0);
`endif
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    amt_d    = amt_q;
    k_d      = k_q;
    mant_d   = mant_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = {mant_in, 2'b00};
          sticky_d = 1'b0;
          amt_d    = shift_amt;
          k_d      = KW'(SHIFT_W - 1);
          state_d  = SHIFT;
`ifdef ALIGN_EARLY_EXIT_EN
          // A zero shift is already aligned: publish the operand directly.
          if (shift_amt == '0) begin
            state_d = DONE;
            mant_d  = mant_in;
            g_d     = 1'b0;
            r_d     = 1'b0;
            s_d     = 1'b0;
          end
`endif
        end
      end
      SHIFT: begin
        work_d   = shifted_work;
        sticky_d = shifted_sticky;
        k_d      = k_q - KW'(1);
        if (last_stage) begin
          state_d = DONE;
          mant_d  = shifted_work[W-1:2];
          g_d     = shifted_work[1];
          r_d     = shifted_work[0];
          s_d     = shifted_sticky;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      sticky_q <= 1'b0;
      amt_q    <= '0;
      k_q      <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      amt_q    <= amt_d;
      k_q      <= k_d;
      mant_q   <= mant_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign mant_out  = mant_q;
  assign g         = g_q;
  assign r         = r_q;
  assign s         = s_q;

endmodule

// File: tb/tb_align_shift_grs.sv
// Directed bench for align_shift_grs (MANT_W=24, SHIFT_W=5).
module tb_align_shift_grs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] mant_in;
  logic [4:0]  shift_amt;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant_out;
  logic        g, r, s;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  align_shift_grs #(.MANT_W(24), .SHIFT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .shift_amt (shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .g         (g),
    .r         (r),
    .s         (s),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_res(input logic [23:0] m, input logic gg,
                                           input logic rr, input logic ss);
    return {5'b0, m, gg, rr, ss};
  endfunction

  // Edges after the accept edge until out_valid is visible.
  function automatic int exp_lat(input logic [4:0] sh);
`ifdef ALIGN_EARLY_EXIT_EN
    // Zero shift reaches DONE on the accept edge itself.
    if (sh == 5'd0) return 0;
    for (int i = 0; i < 5; i++) if (sh[i]) return 5 - i;
    return 5;
`else
    return 5;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [23:0] m, input logic [4:0] sh);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    mant_in   = m;
    shift_amt = sh;
    tick();
    in_valid  = 1'b0;
    mant_in   = 24'h5A5A5A;
    shift_amt = 5'h1F;
  endtask

  task automatic run_op(input logic [23:0] m, input logic [4:0] sh,
                        input logic [23:0] em, input logic eg, input logic er,
                        input logic es, input int hold);
    int lat;
    logic [31:0] exp_res;
    int stray;
    exp_res = pack_res(em, eg, er, es);
    start_op(m, sh);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat(sh)));
    check("result", pack_res(mant_out, g, r, s), exp_res);
    check("busy_done", 32'(busy), 32'd1);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      mant_in  = ~m;
      shift_amt = 5'd0;
      tick();
      check("hold_result", pack_res(mant_out, g, r, s), exp_res);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("retained", pack_res(mant_out, g, r, s), exp_res);
    if (hold > 0) begin
      stray = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (out_valid || busy) stray++;
      end
      check("dropped_input", 32'(stray), 32'd0);
    end
    $display("[TB] op mant=0x%06h shift=%0d -> mant=0x%06h g=%0d r=%0d s=%0d lat=%0d hold=%0d",
             m, sh, mant_out, g, r, s, lat, hold);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mant_in   = 24'hFFFFFF;
    shift_amt = 5'd3;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", pack_res(mant_out, g, r, s), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    $display("[TB] reset done");

    run_op(24'h800001, 5'd0,  24'h800001, 1'b0, 1'b0, 1'b0, 0);
    run_op(24'hC00005, 5'd3,  24'h180000, 1'b1, 1'b0, 1'b1, 0);
    run_op(24'h800000, 5'd24, 24'h000000, 1'b1, 1'b0, 1'b0, 0);
    run_op(24'h800000, 5'd25, 24'h000000, 1'b0, 1'b1, 1'b0, 0);
    run_op(24'hFFFFFF, 5'd31, 24'h000000, 1'b0, 1'b0, 1'b1, 0);
    run_op(24'hABCDEF, 5'd24, 24'h000000, 1'b1, 1'b0, 1'b1, 0);
    run_op(24'h000001, 5'd26, 24'h000000, 1'b0, 1'b0, 1'b1, 0);
    run_op(24'h123456, 5'h10, 24'h000012, 1'b0, 1'b0, 1'b1, 0);
    run_op(24'h123456, 5'h01, 24'h091A2B, 1'b0, 1'b0, 1'b0, 0);
    // Backpressure with concurrent in_valid held off for 10 cycles.
    run_op(24'hC00005, 5'd3,  24'h180000, 1'b1, 1'b0, 1'b1, 10);

    // Reset two edges after accept discards the operation.
    start_op(24'hFFFFFF, 5'd31);
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", pack_res(mant_out, g, r, s), 32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    $display("[TB] reset mid-operation: stray cycles=%0d", seen);

    run_op(24'h800001, 5'd1,  24'h400000, 1'b1, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
